// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetch PCs, reads a word-addressed array,
// and returns responses in order after a fixed latency through a bounded queue.
module imem_responder #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [DATA_WIDTH-1:0]        req_pc,
    input  logic                         flush,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [DATA_WIDTH-1:0]        resp_pc,
    output logic [DATA_WIDTH-1:0]        resp_instr,
    output logic                         resp_err,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]        ld_data
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned QW = $clog2(QUEUE_DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP      = DATA_WIDTH'(32'h0000_0013);
    localparam logic [DATA_WIDTH:0]   PC_LIMIT = (DATA_WIDTH+1)'(64'(4) * 64'(MEM_WORDS));

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic                  accept;
    logic                  deliver;
    logic                  q_nonempty;
    logic [QW:0]           count;
    logic [QW:0]           q_used;
    logic [QW-1:0]         wr_ptr;
    logic [QW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] q_pc    [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] q_instr [QUEUE_DEPTH];
    logic                  q_err   [QUEUE_DEPTH];

    logic [AW-1:0]         in_idx;
    logic                  in_err;
    logic [DATA_WIDTH-1:0] in_instr;

    logic                  q_push;
    logic [DATA_WIDTH-1:0] push_pc;
    logic [DATA_WIDTH-1:0] push_instr;
    logic                  push_err;

    // count covers both the pipeline and the queue, so the queue can never overflow
    assign req_ready  = rst && !flush && (count < (QW+1)'(QUEUE_DEPTH));
    assign accept     = req_valid && req_ready;
    assign q_nonempty = (q_used != '0);
    assign resp_valid = q_nonempty && !flush;
    assign deliver    = resp_valid && resp_ready;

    assign resp_pc    = q_nonempty ? q_pc[rd_ptr]    : '0;
    assign resp_instr = q_nonempty ? q_instr[rd_ptr] : '0;
    assign resp_err   = q_nonempty ? q_err[rd_ptr]   : 1'b0;

    always_comb begin
        in_idx   = req_pc[AW+1:2];
        in_err   = (req_pc[1:0] != 2'b00) || ({1'b0, req_pc} >= PC_LIMIT);
        in_instr = in_err ? NOP : mem[in_idx];
    end

    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // The array read is captured by the first register level, so a same-edge
    // load write is seen only by later requests.
    generate
        if (LATENCY == 1) begin : g_direct
            always_comb begin
                q_push     = accept;
                push_pc    = req_pc;
                push_instr = in_instr;
                push_err   = in_err;
            end
        end else begin : g_piped
            localparam int unsigned STAGES = LATENCY - 1;

            logic [STAGES-1:0]     st_valid;
            logic [DATA_WIDTH-1:0] st_pc    [STAGES];
            logic [DATA_WIDTH-1:0] st_instr [STAGES];
            logic                  st_err   [STAGES];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    st_valid <= '0;
                end else if (flush) begin
                    st_valid <= '0;
                end else begin
                    st_valid[0] <= accept;
                    for (int unsigned i = 1; i < STAGES; i++) begin
                        st_valid[i] <= st_valid[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                st_pc[0]    <= req_pc;
                st_instr[0] <= in_instr;
                st_err[0]   <= in_err;
                for (int unsigned i = 1; i < STAGES; i++) begin
                    st_pc[i]    <= st_pc[i-1];
                    st_instr[i] <= st_instr[i-1];
                    st_err[i]   <= st_err[i-1];
                end
            end

            always_comb begin
                q_push     = st_valid[STAGES-1];
                push_pc    = st_pc[STAGES-1];
                push_instr = st_instr[STAGES-1];
                push_err   = st_err[STAGES-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_used <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_used <= '0;
            count  <= '0;
        end else begin
            if (q_push) begin
                wr_ptr <= wr_ptr + QW'(1);
            end
            if (deliver) begin
                rd_ptr <= rd_ptr + QW'(1);
            end
            q_used <= q_used + (QW+1)'(q_push) - (QW+1)'(deliver);
            count  <= count + (QW+1)'(accept) - (QW+1)'(deliver);
        end
    end

    always_ff @(posedge clk) begin
        if (q_push) begin
            q_pc[wr_ptr]    <= push_pc;
            q_instr[wr_ptr] <= push_instr;
            q_err[wr_ptr]   <= push_err;
        end
    end

endmodule
